// File: rtl/bin_to_bcd3_pkg.sv
// Shared types and constants for the bin_to_bcd3 converter.
package bin_to_bcd_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned N_DIGITS_INT = 4;
  localparam int unsigned MAX_DISPLAY  = 999;
  localparam int unsigned SCR_W        = BCD_W * N_DIGITS_INT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Registered conversion result as presented to the display path.
  typedef struct packed {
    logic             ovf;
    logic [BCD_W-1:0] d2;
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } bcd_result_t;

endpackage

// File: rtl/bin_to_bcd3_if.sv
// Start/ready/done handshake plus result digits for bin_to_bcd3.
interface bin_to_bcd3_if #(
  parameter int unsigned WIDTH = 10
);

  logic             start;
  logic [WIDTH-1:0] bin;
  logic             ready;
  logic             done;
  logic [3:0]       bcd0;
  logic [3:0]       bcd1;
  logic [3:0]       bcd2;
  logic             ovf;

  modport master (
    output start, bin,
    input  ready, done, bcd0, bcd1, bcd2, ovf
  );

  modport slave (
    input  start, bin,
    output ready, done, bcd0, bcd1, bcd2, ovf
  );

endinterface

// File: rtl/bin_to_bcd3_add3.sv
// Double-dabble nibble correction: values 5..9 get +3 before the shift.
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nib_i,
  output logic [BCD_W-1:0] nib_o
);

  assign nib_o = (nib_i >= BCD_W'(5)) ? nib_i + BCD_W'(3) : nib_i;

endmodule

// File: rtl/bin_to_bcd3.sv
// Sequential double-dabble binary -> 3-digit BCD converter, one bit per clock.
// Build option: define OVF_CLAMP_EN to show 999 on overflow instead of the low
// three decimal digits.
module bin_to_bcd3
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic         clk,
  input  logic         reset,
  bin_to_bcd3_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [SCR_W-1:0]   scr_q, scr_d, scr_adj;
  logic [CNT_W-1:0]   n_q, n_d;
  bcd_result_t        res_q, res_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               ovf_c;

  // Per-nibble add-3 correction applied to the scratch register each step.
  for (genvar g = 0; g < N_DIGITS_INT; g++) begin : g_adj
    bcd_add3 u_add3 (
      .nib_i(scr_q[g*BCD_W +: BCD_W]),
      .nib_o(scr_adj[g*BCD_W +: BCD_W])
    );
  end

  assign ovf_c = (scr_q[SCR_W-1 -: BCD_W] != '0);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    n_d     = n_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin;
          scr_d   = '0;
          n_d     = CNT_W'(WIDTH);
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        {scr_d, sh_d} = {scr_adj, sh_q} << 1;
        n_d           = n_q - CNT_W'(1);
        if (n_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_d.ovf = ovf_c;
`ifdef OVF_CLAMP_EN
        if (ovf_c) begin
          res_d.d2 = BCD_W'(9);
          res_d.d1 = BCD_W'(9);
          res_d.d0 = BCD_W'(9);
        end else begin
          res_d.d2 = scr_q[2*BCD_W +: BCD_W];
          res_d.d1 = scr_q[1*BCD_W +: BCD_W];
          res_d.d0 = scr_q[0 +: BCD_W];
        end
`else
        res_d.d2 = scr_q[2*BCD_W +: BCD_W];
        res_d.d1 = scr_q[1*BCD_W +: BCD_W];
        res_d.d0 = scr_q[0 +: BCD_W];
`endif
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      n_q     <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      n_q     <= n_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.bcd0  = res_q.d0;
  assign bus.bcd1  = res_q.d1;
  assign bus.bcd2  = res_q.d2;
  assign bus.ovf   = res_q.ovf;

endmodule

// File: tb/tb_bin_to_bcd3.sv
// Scoreboard bench for bin_to_bcd3: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_bin_to_bcd3;

  localparam int unsigned WIDTH = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd3_if #(.WIDTH(WIDTH)) bus ();

  bin_to_bcd3 #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [12:0] res;
    int          due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] pk(input logic o, input int d2, input int d1, input int d0);
    return {o, 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  // Decimal reference model used for the sweep.
  function automatic logic [12:0] ref_model(input int v);
    logic o;
    o = (v > 999);
`ifdef OVF_CLAMP_EN
    if (o) return pk(1'b1, 9, 9, 9);
`endif
    return pk(o, (v / 100) % 10, (v / 10) % 10, v % 10);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: compare each done pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_width", int'(bus.done), 0);
      prev_done = bus.done;
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", int'({bus.ovf, bus.bcd2, bus.bcd1, bus.bcd0}), int'(e.res));
          chk("latency", cyc, e.due);
        end
      end
    end
  end

  // Issue one conversion from a negedge with ready expected high.
  task automatic issue(input int v, input logic [12:0] exp_res);
    chk("ready_before_start", int'(bus.ready), 1);
    bus.start = 1'b1;
    bus.bin   = WIDTH'(v);
    @(negedge clk);
    q.push_back('{res: exp_res, due: cyc + WIDTH + 1});
    bus.start = 1'b0;
    chk("ready_drop", int'(bus.ready), 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_digits", int'({bus.ovf, bus.bcd2, bus.bcd1, bus.bcd0}), 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed values including the overflow boundary
    issue(0, pk(1'b0, 0, 0, 0));    wait_ready();
    issue(999, pk(1'b0, 9, 9, 9));  wait_ready();
`ifdef OVF_CLAMP_EN
    issue(1023, pk(1'b1, 9, 9, 9)); wait_ready();
    issue(1000, pk(1'b1, 9, 9, 9)); wait_ready();
`else
    issue(1023, pk(1'b1, 0, 2, 3)); wait_ready();
    issue(1000, pk(1'b1, 0, 0, 0)); wait_ready();
`endif
    issue(100, pk(1'b0, 1, 0, 0));  wait_ready();
    issue(58, pk(1'b0, 0, 5, 8));   wait_ready();

    // Start during conversion is ignored
    issue(357, pk(1'b0, 3, 5, 7));
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = WIDTH'(42);
    @(negedge clk);
    chk("busy_ready", int'(bus.ready), 0);
    bus.start = 1'b0;
    wait_ready();
    repeat (15) @(negedge clk);
    chk("ignored_start_queue", q.size(), 0);
    chk("hold_digits", int'({bus.ovf, bus.bcd2, bus.bcd1, bus.bcd0}), int'(pk(1'b0, 3, 5, 7)));

    // Reset mid-conversion aborts without a done pulse
    bus.start = 1'b1;
    bus.bin   = WIDTH'(500);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_digits", int'({bus.ovf, bus.bcd2, bus.bcd1, bus.bcd0}), 0);
    chk("abort_ready", int'(bus.ready), 1);
    @(negedge clk);
    chk("abort_ready_after", int'(bus.ready), 1);
    repeat (20) @(negedge clk);

    // Start held high, sweep 0..999 back to back
    for (int v = 0; v < 1000; v++) begin
      int n;
      n = 0;
      while (!bus.ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!bus.ready) chk("sweep_ready_timeout", 0, 1);
      bus.bin   = WIDTH'(v);
      bus.start = 1'b1;
      q.push_back('{res: ref_model(v), due: cyc + 1 + WIDTH + 1});
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
